// File: rtl/rename_pkg.sv
// Shared types and default widths for the rename register file.
// Imported by the interface, the top and the bench.
package rename_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int TAG_W_DEF    = 5;
  localparam int NUM_READ_DEF = 2;
  localparam int REG_IDX_W    = $clog2(NUM_REGS_DEF);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [TAG_W_DEF-1:0] rob_tag_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    rob_tag_t tag;
  } rename_req_t;

  typedef struct packed {
    logic                valid;
    reg_idx_t            rd;
    rob_tag_t            tag;
    logic [XLEN_DEF-1:0] val;
  } commit_req_t;

  // Register 0 is hardwired zero; any request naming it is ignored.
  function automatic logic idx_is_live(input logic [REG_IDX_W-1:0] idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/rename_regfile_if.sv
// Dispatch-side bundle of the rename register file: rename, commit, flush and operand reads.
// The master (decoder/ROB/dispatch side) drives requests; the slave is the register file.
interface rename_regfile_if
  import rename_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int NUM_READ = NUM_READ_DEF
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = IDX_W + 1;

  // Handshake: rename_valid/commit_valid are single-cycle valid-only strobes with
  // no ready; the register file accepts every valid request at the next rising edge.
  // Reads are combinational and always available.
  logic                               flush;
  logic                               rename_valid;
  logic [IDX_W-1:0]                   rename_rd;
  logic [TAG_W-1:0]                   rename_tag;
  logic                               commit_valid;
  logic [IDX_W-1:0]                   commit_rd;
  logic [TAG_W-1:0]                   commit_tag;
  logic [XLEN-1:0]                    commit_val;
  logic [NUM_READ-1:0][IDX_W-1:0]     rd_addr;
  logic [NUM_READ-1:0][XLEN-1:0]      rd_val;
  logic [NUM_READ-1:0]                rd_busy;
  logic [NUM_READ-1:0][TAG_W-1:0]     rd_tag;
  logic [CNT_W-1:0]                   busy_count;

  modport master (
    output flush, rename_valid, rename_rd, rename_tag,
    output commit_valid, commit_rd, commit_tag, commit_val,
    output rd_addr,
    input  rd_val, rd_busy, rd_tag, busy_count
  );

  modport slave (
    input  flush, rename_valid, rename_rd, rename_tag,
    input  commit_valid, commit_rd, commit_tag, commit_val,
    input  rd_addr,
    output rd_val, rd_busy, rd_tag, busy_count
  );

endinterface

// File: rtl/rename_popcount.sv
// Combinational population count of an N-bit vector.
module rename_popcount #(
  parameter int N     = 32,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic [N-1:0]     bits,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register busy bit and producer ROB tag.
// Optional same-cycle commit-to-read bypass: define RENAME_REGFILE_BYPASS_EN.
module rename_regfile
  import rename_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int NUM_READ = NUM_READ_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  rename_regfile_if.slave rf
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = IDX_W + 1;

  logic [XLEN-1:0]     val_q  [NUM_REGS];
  logic [TAG_W-1:0]    tag_q  [NUM_REGS];
  logic [TAG_W-1:0]    tag_d  [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [CNT_W-1:0]    busy_cnt_d;
  logic [CNT_W-1:0]    busy_count_q;

  logic commit_hit;
  logic commit_match;
  logic rename_hit;

  assign commit_hit   = rf.commit_valid && (rf.commit_rd != '0);
  assign commit_match = commit_hit && busy_q[rf.commit_rd] &&
                        (tag_q[rf.commit_rd] == rf.commit_tag);
  assign rename_hit   = rf.rename_valid && (rf.rename_rd != '0) && !rf.flush;

  // Ordering inside one edge: commit clears, then flush or rename overrides it.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      tag_d[i] = tag_q[i];
    end
    if (commit_match) begin
      busy_d[rf.commit_rd] = 1'b0;
      tag_d[rf.commit_rd]  = '0;
    end
    if (rf.flush) begin
      busy_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_d[i] = '0;
      end
    end else if (rename_hit) begin
      busy_d[rf.rename_rd] = 1'b1;
      tag_d[rf.rename_rd]  = rf.rename_tag;
    end
  end

  rename_popcount #(
    .N     (NUM_REGS),
    .CNT_W (CNT_W)
  ) u_popcount (
    .bits  (busy_d),
    .count (busy_cnt_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      busy_count_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_cnt_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Values ignore flush: the committing ROB head is architectural.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= '0;
      end
    end else if (commit_hit) begin
      val_q[rf.commit_rd] <= rf.commit_val;
    end
  end

  logic [NUM_READ-1:0][XLEN-1:0]  rd_val_c;
  logic [NUM_READ-1:0]            rd_busy_c;
  logic [NUM_READ-1:0][TAG_W-1:0] rd_tag_c;

  always_comb begin
    for (int p = 0; p < NUM_READ; p++) begin
      rd_val_c[p]  = val_q[rf.rd_addr[p]];
      rd_busy_c[p] = busy_q[rf.rd_addr[p]];
      rd_tag_c[p]  = busy_q[rf.rd_addr[p]] ? tag_q[rf.rd_addr[p]] : '0;
`ifdef RENAME_REGFILE_BYPASS_EN
      if (commit_hit && (rf.rd_addr[p] == rf.commit_rd)) begin
        rd_val_c[p] = rf.commit_val;
        if (commit_match) begin
          rd_busy_c[p] = 1'b0;
          rd_tag_c[p]  = '0;
        end
      end
`endif
      if (rf.rd_addr[p] == '0) begin
        rd_val_c[p]  = '0;
        rd_busy_c[p] = 1'b0;
        rd_tag_c[p]  = '0;
      end
    end
  end

  assign rf.rd_val     = rd_val_c;
  assign rf.rd_busy    = rd_busy_c;
  assign rf.rd_tag     = rd_tag_c;
  assign rf.busy_count = busy_count_q;

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: reset, rename/commit, stale tags, flush, bypass, reg 0.
module tb_rename_regfile;
  import rename_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rename_regfile_if #(
    .XLEN(32), .NUM_REGS(32), .TAG_W(5), .NUM_READ(2)
  ) rf_if ();

  rename_regfile #(
    .XLEN(32), .NUM_REGS(32), .TAG_W(5), .NUM_READ(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf_if.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    rf_if.flush        = 1'b0;
    rf_if.rename_valid = 1'b0;
    rf_if.rename_rd    = '0;
    rf_if.rename_tag   = '0;
    rf_if.commit_valid = 1'b0;
    rf_if.commit_rd    = '0;
    rf_if.commit_tag   = '0;
    rf_if.commit_val   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_rename(input reg_idx_t rd, input rob_tag_t tag);
    rf_if.rename_valid = 1'b1;
    rf_if.rename_rd    = rd;
    rf_if.rename_tag   = tag;
  endtask

  task automatic do_commit(input reg_idx_t rd, input rob_tag_t tag, input logic [31:0] val);
    rf_if.commit_valid = 1'b1;
    rf_if.commit_rd    = rd;
    rf_if.commit_tag   = tag;
    rf_if.commit_val   = val;
  endtask

  task automatic read(input int port, input reg_idx_t addr);
    rf_if.rd_addr[port] = addr;
    #1;
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_port(input string tag, input int p, input logic [31:0] v,
                            input logic b, input logic [4:0] t);
    check({tag, "_val"},  64'(rf_if.rd_val[p]),  64'(v));
    check({tag, "_busy"}, 64'(rf_if.rd_busy[p]), 64'(b));
    check({tag, "_tag"},  64'(rf_if.rd_tag[p]),  64'(t));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    rf_if.rd_addr = '0;

    // 1) reset
    read(1, 5'd5);
    check_port("rst_r0", 0, 32'h0, 1'b0, 5'd0);
    check_port("rst_r5", 1, 32'h0, 1'b0, 5'd0);
    check("rst_cnt", 64'(rf_if.busy_count), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 2) rename then matching commit
    do_rename(5'd5, 5'd3);
    tick();
    check_port("t2_busy", 1, 32'h0, 1'b1, 5'd3);
    check("t2_cnt1", 64'(rf_if.busy_count), 64'd1);
    do_commit(5'd5, 5'd3, 32'hDEADBEEF);
    tick();
    check_port("t2_done", 1, 32'hDEADBEEF, 1'b0, 5'd0);
    check("t2_cnt0", 64'(rf_if.busy_count), 64'd0);

    // 3) stale-tag commit
    do_rename(5'd7, 5'd2);
    tick();
    do_rename(5'd7, 5'd9);
    tick();
    do_commit(5'd7, 5'd2, 32'h11);
    tick();
    read(1, 5'd7);
    check_port("t3_stale", 1, 32'h11, 1'b1, 5'd9);
    check("t3_cnt", 64'(rf_if.busy_count), 64'd1);

    // 4) commit and rename same reg, same cycle
    do_commit(5'd4, 5'd1, 32'h22);
    do_rename(5'd4, 5'd6);
    tick();
    read(0, 5'd4);
    check_port("t4_same", 0, 32'h22, 1'b1, 5'd6);
    check("t4_cnt", 64'(rf_if.busy_count), 64'd2);

    // 4b) commit x4 and rename x10 independently
    do_commit(5'd4, 5'd6, 32'h33);
    do_rename(5'd10, 5'd12);
    tick();
    check_port("t4b_x4", 0, 32'h33, 1'b0, 5'd0);
    read(1, 5'd10);
    check_port("t4b_x10", 1, 32'h0, 1'b1, 5'd12);
    check("t4b_cnt", 64'(rf_if.busy_count), 64'd2);

    // 5) flush with same-cycle rename and commit
    do_rename(5'd1, 5'd1);
    tick();
    do_rename(5'd2, 5'd2);
    tick();
    do_rename(5'd3, 5'd3);
    tick();
    check("t5_pre_cnt", 64'(rf_if.busy_count), 64'd5);
    rf_if.flush = 1'b1;
    do_rename(5'd8, 5'd1);
    do_commit(5'd2, 5'd7, 32'h5);
    tick();
    read(0, 5'd8);
    check_port("t5_x8", 0, 32'h0, 1'b0, 5'd0);
    read(1, 5'd2);
    check_port("t5_x2", 1, 32'h5, 1'b0, 5'd0);
    read(0, 5'd7);
    check_port("t5_x7", 0, 32'h11, 1'b0, 5'd0);
    read(1, 5'd5);
    check_port("t5_x5", 1, 32'hDEADBEEF, 1'b0, 5'd0);
    check("t5_cnt", 64'(rf_if.busy_count), 64'd0);

    // 6) same-cycle commit visible on the read port only with bypass
    do_rename(5'd9, 5'd4);
    tick();
    do_commit(5'd9, 5'd4, 32'h77);
    read(0, 5'd9);
`ifdef RENAME_REGFILE_BYPASS_EN
    check_port("t6_byp", 0, 32'h77, 1'b0, 5'd0);
`else
    check_port("t6_nobyp", 0, 32'h0, 1'b1, 5'd4);
`endif
    tick();
    check_port("t6_after", 0, 32'h77, 1'b0, 5'd0);
    check("t6_cnt", 64'(rf_if.busy_count), 64'd0);

    // 7) rd=0 ignored on both ports
    do_rename(5'd0, 5'd5);
    do_commit(5'd0, 5'd5, 32'hFF);
    read(0, 5'd0);
    check_port("t7_r0_now", 0, 32'h0, 1'b0, 5'd0);
    tick();
    check_port("t7_r0", 0, 32'h0, 1'b0, 5'd0);
    check("t7_cnt", 64'(rf_if.busy_count), 64'd0);

    // 8) asynchronous reset mid-operation
    do_rename(5'd11, 5'd8);
    do_commit(5'd9, 5'd0, 32'hABCD);
    #2;
    rst_n = 1'b0;
    #1;
    read(0, 5'd9);
    check_port("t8_x9", 0, 32'h0, 1'b0, 5'd0);
    read(1, 5'd11);
    check_port("t8_x11", 1, 32'h0, 1'b0, 5'd0);
    check("t8_cnt", 64'(rf_if.busy_count), 64'd0);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
